// File: rtl/fram_pkg.sv
// Shared definitions for the frame generator / checker pair.
package fram_pkg;

    localparam int unsigned PAYLOAD_W = 64;
    localparam int unsigned BLOCK_W   = 66;

    localparam logic [1:0] HDR_DATA = 2'b01;
    localparam logic [1:0] HDR_CTRL = 2'b10;

    typedef enum logic {
        UNLOCK = 1'b0,
        LOCK   = 1'b1
    } chk_state_e;

endpackage

// File: rtl/sat_cnt.sv
// Saturating statistics counter; clear takes priority over increment.
module sat_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_d, cnt_q;

    // Next count: clear, or increment unless already at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/chk_fram_mod.sv
// Receive-side frame checker: follows the generator's incrementing payload
// sequence, tracks lock, and keeps saturating error/frame statistics.
module chk_fram_mod
    import fram_pkg::*;
#(
    parameter int unsigned LOCK_CNT   = 16,
    parameter int unsigned UNLOCK_CNT = 4,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PAYLOAD_W-1:0] dat_in,
    input  logic [1:0]           head_in,
    input  logic                 dat_nd,
    input  logic                 clr,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [CNT_W-1:0]     frm_cnt,
    output logic [CNT_W-1:0]     seq_err_cnt,
    output logic [CNT_W-1:0]     hdr_err_cnt
);

    localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned BAD_W  = $clog2(UNLOCK_CNT + 1);
    localparam logic [GOOD_W-1:0] GOOD_TH = GOOD_W'(LOCK_CNT);
    localparam logic [BAD_W-1:0]  BAD_TH  = BAD_W'(UNLOCK_CNT);

    chk_state_e           state_d, state_q;
    logic [PAYLOAD_W-1:0] exp_d, exp_q;
    logic [GOOD_W-1:0]    good_d, good_q;
    logic [BAD_W-1:0]     bad_d, bad_q;
    logic                 err_d, err_q;
    logic                 seq_inc, hdr_inc;

    // Frame classification, run tracking and lock state transitions.
    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        good_d  = good_q;
        bad_d   = bad_q;
        err_d   = 1'b0;
        seq_inc = 1'b0;
        hdr_inc = 1'b0;

        if (dat_nd) begin
            case (head_in)
                HDR_DATA: begin
                    // Both a match and a resync leave expected at payload + 1.
                    exp_d = dat_in + PAYLOAD_W'(1);
                    if (state_q == UNLOCK) begin
                        // A mismatching frame starts a fresh run of one.
                        good_d = (dat_in == exp_q) ? good_q + GOOD_W'(1) : GOOD_W'(1);
                    end else if (dat_in != exp_q) begin
                        seq_inc = 1'b1;
                        err_d   = 1'b1;
                        bad_d   = bad_q + BAD_W'(1);
                    end else begin
                        bad_d = '0;
                    end
                end
                HDR_CTRL: begin
                    // Idle/control: payload ignored, run counters untouched.
                end
                default: begin
                    hdr_inc = 1'b1;
                    err_d   = 1'b1;
                    if (state_q == LOCK) begin
                        bad_d = bad_q + BAD_W'(1);
                    end else begin
                        good_d = '0;
                    end
                end
            endcase

            if ((state_q == UNLOCK) && (good_d >= GOOD_TH)) begin
                state_d = LOCK;
                bad_d   = '0;
            end else if ((state_q == LOCK) && (bad_d >= BAD_TH)) begin
                state_d = UNLOCK;
                good_d  = '0;
            end
        end
    end

    // Checker state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= UNLOCK;
            exp_q   <= '0;
            good_q  <= '0;
            bad_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
            err_q   <= err_d;
        end
    end

    assign locked    = (state_q == LOCK);
    assign err_pulse = err_q;

    sat_cnt #(
        .CNT_W(CNT_W)
    ) u_frm_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc_i(dat_nd),
        .clr_i(clr),
        .cnt_o(frm_cnt)
    );

    sat_cnt #(
        .CNT_W(CNT_W)
    ) u_seq_err_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc_i(seq_inc),
        .clr_i(clr),
        .cnt_o(seq_err_cnt)
    );

    sat_cnt #(
        .CNT_W(CNT_W)
    ) u_hdr_err_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc_i(hdr_inc),
        .clr_i(clr),
        .cnt_o(hdr_err_cnt)
    );

endmodule

// File: tb/tb_chk_fram_mod.sv
// Bench for chk_fram_mod: a reference model pushes expected outputs per cycle,
// popped and compared after each edge. A second instance uses 4-bit counters.
module tb_chk_fram_mod;
    import fram_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic [63:0] dat_in = '0;
    logic [1:0]  head_in = 2'b00;
    logic        dat_nd = 1'b0;
    logic        clr = 1'b0;

    logic        a_locked, a_err;
    logic [31:0] a_frm, a_seq, a_hdr;
    logic        b_locked, b_err;
    logic [3:0]  b_frm, b_seq, b_hdr;

    chk_fram_mod #(.LOCK_CNT(16), .UNLOCK_CNT(4), .CNT_W(32)) u_dut_a (
        .clk(clk), .rst(rst), .dat_in(dat_in), .head_in(head_in), .dat_nd(dat_nd),
        .clr(clr), .locked(a_locked), .err_pulse(a_err), .frm_cnt(a_frm),
        .seq_err_cnt(a_seq), .hdr_err_cnt(a_hdr)
    );

    chk_fram_mod #(.LOCK_CNT(16), .UNLOCK_CNT(4), .CNT_W(4)) u_dut_b (
        .clk(clk), .rst(rst), .dat_in(dat_in), .head_in(head_in), .dat_nd(dat_nd),
        .clr(clr), .locked(b_locked), .err_pulse(b_err), .frm_cnt(b_frm),
        .seq_err_cnt(b_seq), .hdr_err_cnt(b_hdr)
    );

    typedef struct {
        logic        locked;
        logic        err;
        logic [31:0] frm;
        logic [31:0] seq;
        logic [31:0] hdr;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state.
    bit          m_lock;
    bit          m_err;
    logic [63:0] m_exp;
    int          m_good, m_bad;
    logic [31:0] m_frm, m_seq, m_hdr;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] sat4(input logic [31:0] v);
        return (v > 32'd15) ? 32'd15 : v;
    endfunction

    task automatic model(input logic [63:0] d, input logic [1:0] h, input bit nd, input bit c,
                         input bit r);
        m_err = 1'b0;
        if (r) begin
            m_lock = 1'b0; m_exp = '0; m_good = 0; m_bad = 0;
            m_frm = '0; m_seq = '0; m_hdr = '0;
            return;
        end
        if (nd) begin
            m_frm++;
            if (h == 2'b01) begin
                if (!m_lock) begin
                    m_good = (d == m_exp) ? m_good + 1 : 1;
                    if (m_good >= 16) begin
                        m_lock = 1'b1;
                        m_bad  = 0;
                    end
                end else if (d == m_exp) begin
                    m_bad = 0;
                end else begin
                    m_seq++;
                    m_err = 1'b1;
                    m_bad++;
                end
                m_exp = d + 64'd1;
            end else if (h != 2'b10) begin
                m_hdr++;
                m_err = 1'b1;
                if (m_lock) m_bad++;
                else m_good = 0;
            end
            if (m_lock && m_bad >= 4) begin
                m_lock = 1'b0;
                m_good = 0;
            end
        end
        if (c) begin
            m_frm = '0; m_seq = '0; m_hdr = '0;
        end
    endtask

    // Drive one cycle, queue the model's prediction, then compare after the edge.
    task automatic step(input logic [63:0] d, input logic [1:0] h, input bit nd, input bit c,
                        input bit r);
        exp_t e;
        rst = r; dat_in = d; head_in = h; dat_nd = nd; clr = c;
        model(d, h, nd, c, r);
        e.locked = m_lock; e.err = m_err; e.frm = m_frm; e.seq = m_seq; e.hdr = m_hdr;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_eq("a_locked", a_locked, e.locked);
        check_eq("a_err_pulse", a_err, e.err);
        check_eq("a_frm_cnt", a_frm, e.frm);
        check_eq("a_seq_err_cnt", a_seq, e.seq);
        check_eq("a_hdr_err_cnt", a_hdr, e.hdr);
        check_eq("b_locked", b_locked, e.locked);
        check_eq("b_err_pulse", b_err, e.err);
        check_eq("b_frm_cnt", b_frm, sat4(e.frm));
        check_eq("b_seq_err_cnt", b_seq, sat4(e.seq));
        check_eq("b_hdr_err_cnt", b_hdr, sat4(e.hdr));
    endtask

    task automatic data(input logic [63:0] d);
        step(d, 2'b01, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic gap();
        step({$urandom, $urandom}, 2'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] frm0;
        logic [1:0]  hsel [5];
        hsel[0] = 2'b01; hsel[1] = 2'b01; hsel[2] = 2'b01; hsel[3] = 2'b10; hsel[4] = 2'b11;

        // Reset.
        step(64'd0, 2'b01, 1'b1, 1'b0, 1'b1);
        step(64'd0, 2'b01, 1'b1, 1'b0, 1'b1);
        check_eq("rst_locked", a_locked, 1'b0);
        check_eq("rst_frm", a_frm, 32'd0);

        // Lock acquisition on 100..115.
        for (int i = 100; i < 115; i++) data(64'(i));
        check_eq("prelock_locked", a_locked, 1'b0);
        data(64'd115);
        check_eq("lock_locked", a_locked, 1'b1);
        check_eq("lock_frm", a_frm, 32'd16);
        check_eq("lock_seq", a_seq, 32'd0);

        // Walk the sequence up to 199, then single error and resync.
        for (int i = 116; i < 200; i++) data(64'(i));
        data(64'd200);
        data(64'd201);
        data(64'd500);
        check_eq("seqerr_pulse", a_err, 1'b1);
        data(64'd501);
        check_eq("resync_no_pulse", a_err, 1'b0);
        check_eq("resync_seq", a_seq, 32'd1);
        check_eq("resync_locked", a_locked, 1'b1);

        // Header errors drop lock.
        for (int i = 0; i < 4; i++) begin
            step(64'd502, 2'b11, 1'b1, 1'b0, 1'b0);
            check_eq("hdr_pulse", a_err, 1'b1);
        end
        check_eq("hdr_cnt4", a_hdr, 32'd4);
        check_eq("hdr_unlocked", a_locked, 1'b0);

        // Relock just below the 64-bit wrap, then wrap with an idle inserted.
        for (int i = 16; i > 0; i--) data(64'hFFFF_FFFF_FFFF_FFFE - 64'(i));
        check_eq("relock", a_locked, 1'b1);
        frm0 = a_frm;
        data(64'hFFFF_FFFF_FFFF_FFFE);
        step(64'h1234_5678, 2'b10, 1'b1, 1'b0, 1'b0);
        data(64'hFFFF_FFFF_FFFF_FFFF);
        data(64'h0);
        check_eq("wrap_frm_delta", a_frm - frm0, 32'd4);
        check_eq("wrap_seq", a_seq, 32'd1);
        check_eq("wrap_locked", a_locked, 1'b1);

        // Gapped strobe, then clr colliding with a bad frame.
        gap(); gap();
        data(64'd1);
        gap(); gap(); gap();
        data(64'd2);
        step(64'd77, 2'b01, 1'b1, 1'b1, 1'b0);
        check_eq("clr_seq", a_seq, 32'd0);
        check_eq("clr_pulse", a_err, 1'b1);
        gap();
        check_eq("gap_pulse_clear", a_err, 1'b0);

        // Randomised mix of gaps, idles, header errors and occasional bad payloads.
        for (int i = 0; i < 80; i++) begin
            logic [63:0] d;
            d = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom} : m_exp;
            step(d, hsel[$urandom_range(0, 4)], 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 31) == 0), 1'b0);
        end

        // Ensure lock, then reset mid-stream with a frame presented.
        for (int i = 0; i < 16; i++) data(64'(1000 + i));
        check_eq("prerst_locked", a_locked, 1'b1);
        step(64'd1016, 2'b11, 1'b1, 1'b0, 1'b1);
        check_eq("midrst_locked", a_locked, 1'b0);
        check_eq("midrst_frm", a_frm, 32'd0);
        check_eq("midrst_hdr", a_hdr, 32'd0);

        // Saturation of the 4-bit instance.
        for (int i = 0; i < 20; i++) step(64'd0, 2'b00, 1'b1, 1'b0, 1'b0);
        check_eq("sat_b_hdr", b_hdr, 4'd15);
        check_eq("sat_a_hdr", a_hdr, 32'd20);
        check_eq("sat_b_frm", b_frm, 4'd15);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
